// File: rtl/counter_pkg.sv
// counter_pkg: shared types, limits and step function for
// the saturating counter and its job arbiter.
package counter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int CNT_W   = 10;
  localparam int RST_VAL = 17;
  localparam int MIN     = -263;
  localparam int MAX     = 269;
  localparam int INV     = -47;
  localparam int UP_STEP = 4;
  localparam int DN_STEP = 10;

  // One counter step: clamp to [MIN,MAX]; the INV code is
  // never produced, the counter jumps one step past it.
  function automatic logic signed [CNT_W-1:0] cnt_next(
    input logic signed [CNT_W-1:0] c,
    input logic                    up
  );
    int w;
    w = up ? int'(c) + UP_STEP : int'(c) - DN_STEP;
    if (w > MAX)
      w = MAX;
    else if (w < MIN)
      w = MIN;
    if (w == INV)
      w = up ? w + UP_STEP : w - DN_STEP;
    return CNT_W'(w);
  endfunction

endpackage

// File: rtl/counter.sv
// counter: saturating up/down counter, steps every cycle.
// Ports: clk, rst (sync, high), mode (1=up), cnt (signed).
module counter
  import counter_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    mode,
  output logic signed [CNT_W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst)
      cnt <= CNT_W'(RST_VAL);
    else
      cnt <= cnt_next(cnt, mode);
  end

endmodule

// File: rtl/counter_arb.sv
// counter_arb: round-robin arbiter running count jobs from two
// requesters on one counter. Ports: clk, rst, req0/1 valid/
// ready/dir/len, resp valid/ready/id/start/end/sat, cnt, busy.
module counter_arb
  import counter_pkg::*;
#(
  parameter int LEN_W = 8,
  parameter int SAT_W = LEN_W
)
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req0_valid,
  output logic                    req0_ready,
  input  logic                    req0_dir,
  input  logic [LEN_W-1:0]        req0_len,
  input  logic                    req1_valid,
  output logic                    req1_ready,
  input  logic                    req1_dir,
  input  logic [LEN_W-1:0]        req1_len,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic                    resp_id,
  output logic signed [CNT_W-1:0] resp_start,
  output logic signed [CNT_W-1:0] resp_end,
  output logic [SAT_W-1:0]        resp_sat,
  output logic signed [CNT_W-1:0] cnt,
  output logic                    busy
);

  state_t                  state;
  logic                    mode;
  logic                    prio;
  logic [LEN_W-1:0]        rem;
  logic [SAT_W-1:0]        sat;
  logic signed [CNT_W-1:0] nxt;
  logic                    g0;
  logic                    g1;
  logic                    acc;
  logic                    acc_id;
  logic                    acc_dir;
  logic [LEN_W-1:0]        acc_len;

  counter u_cnt (
    .clk  (clk),
    .rst  (rst),
    .mode (mode),
    .cnt  (cnt)
  );

  always_comb begin
    nxt        = cnt_next(cnt, mode);
    g0         = req0_valid && (!req1_valid || !prio);
    g1         = req1_valid && (!req0_valid || prio);
    req0_ready = (state == IDLE) && g0;
    req1_ready = (state == IDLE) && g1;
    acc        = req0_ready || req1_ready;
    acc_id     = req1_ready;
    acc_dir    = req1_ready ? req1_dir : req0_dir;
    acc_len    = req1_ready ? req1_len : req0_len;
  end

  assign resp_valid = (state == RESP);
  assign busy       = (state != IDLE);
  assign resp_sat   = sat;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      mode       <= 1'b1;
      prio       <= 1'b0;
      rem        <= '0;
      sat        <= '0;
      resp_id    <= 1'b0;
      resp_start <= '0;
      resp_end   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (acc) begin
            prio    <= ~acc_id;
            resp_id <= acc_id;
            mode    <= acc_dir;
            sat     <= '0;
            rem     <= acc_len;
            if (acc_len == '0) begin
              state      <= RESP;
              resp_start <= cnt;
              resp_end   <= cnt;
            end else begin
              // cnt seen in the first RUN cycle
              state      <= RUN;
              resp_start <= nxt;
            end
          end
        end
        RUN: begin
          if (nxt == cnt && sat != '1)
            sat <= sat + 1'b1;
          rem <= rem - 1'b1;
          if (rem == LEN_W'(1)) begin
            state    <= RESP;
            resp_end <= nxt;
          end
        end
        RESP: begin
          if (resp_ready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_counter_arb.sv
// tb_counter_arb: directed self-checking bench for counter_arb.
// Vectors carry hand-computed counter values.
module tb_counter_arb;
  import counter_pkg::*;

  localparam int LEN_W = 8;
  localparam int SAT_W = 8;

  logic                    clk;
  logic                    rst;
  logic                    req0_valid;
  logic                    req0_ready;
  logic                    req0_dir;
  logic [LEN_W-1:0]        req0_len;
  logic                    req1_valid;
  logic                    req1_ready;
  logic                    req1_dir;
  logic [LEN_W-1:0]        req1_len;
  logic                    resp_valid;
  logic                    resp_ready;
  logic                    resp_id;
  logic signed [CNT_W-1:0] resp_start;
  logic signed [CNT_W-1:0] resp_end;
  logic [SAT_W-1:0]        resp_sat;
  logic signed [CNT_W-1:0] cnt;
  logic                    busy;

  int ntests = 0;
  int nfail  = 0;

  counter_arb #(.LEN_W(LEN_W), .SAT_W(SAT_W)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_dir   (req0_dir),
    .req0_len   (req0_len),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_dir   (req1_dir),
    .req1_len   (req1_len),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_start (resp_start),
    .resp_end   (resp_end),
    .resp_sat   (resp_sat),
    .cnt        (cnt),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    ntests++;
    if (got != exp) begin
      nfail++;
      $display("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask

  // Offer a job on requester idx (optionally with the other one
  // also valid), then check grant, latency and response.
  task automatic run_job(
    input int   idx,
    input logic dir,
    input int   len,
    input logic ov,
    input logic odir,
    input int   olen,
    input int   eid,
    input int   es,
    input int   ee,
    input int   esat
  );
    int n;
    if (idx == 0) begin
      req0_valid = 1'b1;
      req0_dir   = dir;
      req0_len   = LEN_W'(len);
      req1_valid = ov;
      req1_dir   = odir;
      req1_len   = LEN_W'(olen);
    end else begin
      req1_valid = 1'b1;
      req1_dir   = dir;
      req1_len   = LEN_W'(len);
      req0_valid = ov;
      req0_dir   = odir;
      req0_len   = LEN_W'(olen);
    end
    #1;
    chk("grant", idx == 0 ? req0_ready : req1_ready, 1);
    chk("no_grant", idx == 0 ? req1_ready : req0_ready, 0);
    @(negedge clk);
    if (idx == 0) req0_valid = 1'b0;
    else          req1_valid = 1'b0;
    n = 1;
    while (!resp_valid && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("latency", n, len == 0 ? 1 : len + 1);
    chk("busy_resp", busy, 1);
    chk("rdy_resp", req0_ready | req1_ready, 0);
    chk("resp_id", resp_id, eid);
    chk("resp_start", resp_start, es);
    chk("resp_end", resp_end, ee);
    chk("resp_sat", resp_sat, esat);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    chk("busy_idle", busy, 0);
    chk("rv_idle", resp_valid, 0);
  endtask

  initial begin
    int seen;
    rst        = 1'b1;
    req0_valid = 1'b0;
    req0_dir   = 1'b0;
    req0_len   = '0;
    req1_valid = 1'b0;
    req1_dir   = 1'b0;
    req1_len   = '0;
    resp_ready = 1'b0;

    // reset: one edge
    @(negedge clk);
    chk("rst_cnt", cnt, 17);
    chk("rst_mode", u_dut.mode, 1);
    chk("rst_busy", busy, 0);
    chk("rst_rv", resp_valid, 0);
    chk("rst_rdy", req0_ready | req1_ready, 0);
    chk("rst_start", resp_start, 0);
    chk("rst_sat", resp_sat, 0);
    rst = 1'b0;

    // idle drift up: 17 + 4*63 = 269, then held at MAX
    repeat (70) @(negedge clk);
    chk("drift_max", cnt, 269);

    // req0 up 5 at MAX: every step saturated
    run_job(0, 1'b1, 5, 1'b0, 1'b0, 0, 0, 269, 269, 5);
    chk("cnt_after0", cnt, 269);

    // req1 down 10: 269 - 100 = 169; one idle step after -> 159
    run_job(1, 1'b0, 10, 1'b0, 1'b0, 0, 1, 269, 169, 0);
    chk("cnt_after1", cnt, 159);

    // both valid: req0 wins (prio back at 0).
    // accept step down 159->149, up 3 -> 161, idle step -> 165
    run_job(0, 1'b1, 3, 1'b1, 1'b1, 2, 0, 149, 161, 0);
    chk("cnt_after2", cnt, 165);

    // both valid again: req1 wins. 165->169 start, +8 -> 177
    run_job(1, 1'b1, 2, 1'b1, 1'b1, 2, 1, 169, 177, 0);
    chk("cnt_after3", cnt, 181);

    // zero-length job: start = end = cnt at accept
    run_job(0, 1'b1, 0, 1'b0, 1'b0, 0, 0, 181, 181, 0);
    chk("cnt_after4", cnt, 189);

    // reset in the middle of a RUN
    req0_valid = 1'b1;
    req0_dir   = 1'b0;
    req0_len   = LEN_W'(8);
    @(negedge clk);
    req0_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("run_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_cnt", cnt, 17);
    chk("abort_mode", u_dut.mode, 1);
    chk("abort_rv", resp_valid, 0);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (resp_valid) seen++;
    end
    chk("abort_no_resp", seen, 0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/counter_arb.md
COUNTER_ARB -- requirements
Module: counter_arb

Interface
REQ-001 SHALL have parameter LEN_W, default 8, meaning the width of a job's step count.
REQ-002 SHALL have parameter SAT_W, default LEN_W, meaning the width of the saturated-cycle count.
REQ-003 SHALL provide ports, one per line, as follows:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req0_valid  in  1  requester 0 job offered
- req0_ready  out  1  requester 0 job accepted this cycle
- req0_dir  in  1  1=count up, 0=count down
- req0_len  in  LEN_W  steps requested
- req1_valid/req1_ready/req1_dir/req1_len  same as requester 0
- resp_valid  out  1  job result available
- resp_ready  in  1  result consumed
- resp_id  out  1  requester index of result
- resp_start  out  10 signed  cnt when first step applied
- resp_end  out  10 signed  cnt after last step
- resp_sat  out  SAT_W  steps with no cnt change
- cnt  out  10 signed  live counter value
- busy  out  1  state != IDLE

Function
REQ-004 SHALL contain one instance of the existing counter (clk, rst, mode, cnt); counter_arb is the sole driver of mode.
REQ-005 SHALL use FSM states IDLE, RUN, RESP.
REQ-006 IDLE: SHALL drive mode = last job direction; counter free-runs (drifts), which is accepted behaviour.
REQ-007 IDLE: SHALL assert at most one reqN_ready, combinationally, to the granted valid requester; acceptance = valid&&ready.
REQ-008 Arbitration SHALL be round-robin: if both valid, grant prio pointer; after each accept, pointer = other requester.
REQ-009 On accept with len>0: next cycle RUN, mode=dir, remaining=len, sat=0, resp_id latched.
REQ-010 On accept with len==0: next cycle RESP, resp_start=resp_end=current cnt, resp_sat=0.
REQ-011 RUN: mode=dir every cycle; resp_start = cnt in first RUN cycle; remaining decrements each cycle; exit to RESP after len RUN cycles.
REQ-012 resp_end SHALL equal cnt in the first RESP cycle, i.e. after exactly len steps.
REQ-013 sat SHALL increment each RUN step whose next cnt equals current cnt (counter at limit); saturating at 2^SAT_W-1.
REQ-014 RESP: resp_valid=1, outputs stable, mode held at dir; on resp_ready -> IDLE next cycle.
REQ-015 reqN_ready SHALL be 0 in RUN and RESP; requests arriving then wait.
REQ-016 Delta rule: unsaturated, skip-free up job -> resp_end-resp_start = 4*len; down -> -10*len.

Reset
REQ-017 rst SHALL force: state IDLE, mode=1, prio=req0, resp_valid=0, all ready=0, resp fields 0, busy=0; counter reset to 17.
REQ-018 rst mid-RUN or mid-RESP SHALL abort the job with no response issued.

Structure
REQ-019 SHALL place state enum (IDLE/RUN/RESP), CNT_W=10, RST_VAL=17, MIN=-263, MAX=269, INV=-47, UP_STEP=4, DN_STEP=10 in package counter_pkg.
REQ-020 Counter SHALL remain the single sub-module (counter); arbiter and FSM inline.

Verification
REQ-021 Reset 1 cycle -> cnt=17, mode=1, busy=0, resp_valid=0.
REQ-022 Idle >=70 cycles after reset (mode up) -> cnt=269; req0 up len=5 -> resp_start=269, resp_end=269, resp_sat=5, resp_id=0.
REQ-023 After REQ-022, req1 down len=10 -> resp_end=169, resp_sat=0, resp_id=1.
REQ-024 req0 and req1 valid same cycle, twice -> grants 0 then 1; resp_id order 0,1.
REQ-025 req0 len=0 -> RESP next cycle, resp_start=resp_end, resp_sat=0.
REQ-026 rst asserted in RUN -> next cycle IDLE, cnt=17, no resp_valid.
